// File: rtl/text_pixel_renderer.sv
// text_pixel_renderer: issues font ROM reads and turns the returned row byte into a registered text_on pixel flag.
// Optional frame-based blink is enabled by defining TEXT_BLINK_EN.
module text_pixel_renderer #(
   parameter int ROM_LATENCY  = 1,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [10:0] letter,
   input  logic [2:0]  xOffset,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
   output logic        text_on,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        blink_vis
);
   localparam int D = ROM_LATENCY + 1;

   if (ROM_LATENCY < 1 || ROM_LATENCY > 3 || BLINK_FRAMES < 1) begin : g_bad_cfg
      $error("text_pixel_renderer: unsupported ROM_LATENCY or BLINK_FRAMES");
   end

   logic [10:0]        font_addr_q;
   logic [D-1:0][2:0]  xo_q;
   logic [D-1:0]       vld_q;
   logic [D-1:0][19:0] xy_q;
   logic               text_on_q;
   logic [19:0]        pix_q;
   logic [2:0]         bit_sel;

   // bit 7 is the leftmost pixel, so column c maps to bit 7-c
   assign bit_sel = 3'd7 - xo_q[D-1];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         font_addr_q <= '0;
         xo_q        <= '0;
         vld_q       <= '0;
         xy_q        <= '0;
         text_on_q   <= 1'b0;
         pix_q       <= '0;
      end else begin
         font_addr_q <= letter;
         xo_q        <= {xo_q[D-2:0], xOffset};
         vld_q       <= {vld_q[D-2:0], letter != 11'd0};
         xy_q        <= {xy_q[D-2:0], DrawX, DrawY};
         text_on_q   <= vld_q[D-1] & font_data[bit_sel] & blink_vis;
         pix_q       <= xy_q[D-1];
      end
   end

   assign font_addr = font_addr_q;
   assign text_on   = text_on_q;
   assign pix_x     = pix_q[19:10];
   assign pix_y     = pix_q[9:0];

`ifdef TEXT_BLINK_EN
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   logic [FW-1:0] frame_cnt_q;
   logic          frame_det_q;
   logic          blink_vis_q;
   logic          frame_cond;
   logic          frame_start;
   logic          last_frame;

   // a frame starts on the first cycle of (0,0); holding it there counts once
   assign frame_cond  = (DrawX == 10'd0) && (DrawY == 10'd0);
   assign frame_start = frame_cond & ~frame_det_q;
   assign last_frame  = frame_cnt_q == FW'(BLINK_FRAMES - 1);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_cnt_q <= '0;
         frame_det_q <= 1'b0;
         blink_vis_q <= 1'b1;
      end else begin
         frame_det_q <= frame_cond;
         if (frame_start) begin
            frame_cnt_q <= last_frame ? '0 : frame_cnt_q + 1'b1;
            blink_vis_q <= blink_vis_q ^ last_frame;
         end
      end
   end

   assign blink_vis = blink_vis_q;
`else
   assign blink_vis = 1'b1;
`endif
endmodule

// File: tb/tb_text_pixel_renderer.sv
// tb_text_pixel_renderer: directed vectors against ROM_LATENCY=1 and ROM_LATENCY=2 instances sharing one stimulus.
module tb_text_pixel_renderer;
   typedef struct packed {
      logic [10:0] l;
      logic [2:0]  xo;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        on;
   } vec_t;

   logic        clk     = 1'b0;
   logic        Reset   = 1'b1;
   logic [9:0]  DrawX   = 10'd262;
   logic [9:0]  DrawY   = 10'd303;
   logic [10:0] letter  = 11'd1283;
   logic [2:0]  xOffset = 3'd2;
   logic [10:0] fa0, fa1;
   logic [7:0]  fd0, fd1, r2a;
   logic        on0, on1, bv0, bv1;
   logic [9:0]  px0, px1, py0, py1;
   logic [7:0]  a5 = 8'hA5;
   int          nvec = 0;
   int          nerr = 0;
   int          n = 0;
   logic        rst_h [256];
   vec_t        hist [256];

   always #5 clk = ~clk;

   // font ROM contents: address 0 reads all-ones so letter==0 sees FF
   function automatic logic [7:0] rom_f(input logic [10:0] a);
      return a == 11'd0 ? 8'hFF : a == 11'd1283 ? 8'h20 : a == 11'd1284 ? 8'hA5 : 8'h00;
   endfunction

   always @(posedge clk) begin
      fd0 <= rom_f(fa0);
      r2a <= rom_f(fa1);
      fd1 <= r2a;
   end

   text_pixel_renderer #(.ROM_LATENCY(1), .BLINK_FRAMES(2)) u1 (
      .Clk(clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .letter(letter), .xOffset(xOffset),
      .font_addr(fa0), .font_data(fd0), .text_on(on0), .pix_x(px0), .pix_y(py0), .blink_vis(bv0)
   );

   text_pixel_renderer #(.ROM_LATENCY(2), .BLINK_FRAMES(2)) u2 (
      .Clk(clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .letter(letter), .xOffset(xOffset),
      .font_addr(fa1), .font_data(fd1), .text_on(on1), .pix_x(px1), .pix_y(py1), .blink_vis(bv1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic vec_t mk(input int l, input int xo, input int x, input int y, input logic on);
      return {11'(l), 3'(xo), 10'(x), 10'(y), on};
   endfunction

   // apply one vector at a falling edge, then check outputs at the next falling edge
   task automatic tick(input logic r, input vec_t v);
      Reset = r;
      letter = v.l;
      xOffset = v.xo;
      DrawX = v.x;
      DrawY = v.y;
      rst_h[n] = r;
      hist[n] = v;
      @(negedge clk);
      n++;
      chk($sformatf("font_addr0@%0d", n), 32'(fa0), r ? 32'd0 : 32'(v.l));
      chk($sformatf("font_addr1@%0d", n), 32'(fa1), r ? 32'd0 : 32'(v.l));
      chk($sformatf("blink0@%0d", n), 32'(bv0), 32'd1);
      chk($sformatf("blink1@%0d", n), 32'(bv1), 32'd1);
      for (int d = 0; d < 2; d++) begin
         int   s;
         logic z;
         vec_t e;
         s = n - 3 - d;
         z = s < 0;
         for (int k = (s < 0 ? 0 : s); k < n; k++) z = z | rst_h[k];
         e = '0;
         if (!z) e = hist[s];
         chk($sformatf("text_on_lat%0d@%0d", d + 3, n), 32'(d ? on1 : on0), 32'(e.on));
         chk($sformatf("pix_x_lat%0d@%0d", d + 3, n), 32'(d ? px1 : px0), 32'(e.x));
         chk($sformatf("pix_y_lat%0d@%0d", d + 3, n), 32'(d ? py1 : py0), 32'(e.y));
      end
   endtask

`ifdef TEXT_BLINK_EN
   task automatic drv(input int l, input int xo, input int x, input int y);
      Reset = 1'b0;
      letter = 11'(l);
      xOffset = 3'(xo);
      DrawX = 10'(x);
      DrawY = 10'(y);
      @(negedge clk);
   endtask
`endif

   initial begin
      for (int i = 0; i < 4; i++) tick(1'b1, mk(1283, 2, 262, 303, 1'b0));
      for (int i = 0; i < 4; i++) tick(1'b0, mk(1283, 2, 262, 303, 1'b1));
      for (int i = 0; i < 4; i++) tick(1'b0, mk(1283, 3, 262, 303, 1'b0));
      for (int i = 0; i < 8; i++) tick(1'b0, mk(0, i, 10 + i, 20, 1'b0));
      for (int i = 0; i < 8; i++) tick(1'b0, mk(1284, i, 100 + i, 50, a5[7-i]));
      for (int i = 0; i < 8; i++) tick(i == 2, mk(1284, i, 200 + i, 60, a5[7-i]));
      for (int i = 0; i < 8; i++) tick(1'b0, mk(1284, i, 300 + i, 70, a5[7-i]));
      for (int i = 0; i < 5; i++) tick(1'b0, mk(0, 0, 400 + i, 80, 1'b0));
`ifdef TEXT_BLINK_EN
      for (int i = 0; i < 5; i++) begin
         drv(0, 0, 0, 0);
         chk($sformatf("blink_hold%0d", i), 32'(bv0), 32'd1);
      end
      drv(0, 0, 1, 0);
      drv(0, 0, 0, 0);
      chk("blink_off0", 32'(bv0), 32'd0);
      chk("blink_off1", 32'(bv1), 32'd0);
      for (int i = 0; i < 4; i++) drv(1283, 2, 262, 303);
      chk("blink_dark0", 32'(on0), 32'd0);
      chk("blink_dark1", 32'(on1), 32'd0);
      drv(0, 0, 0, 0);
      chk("blink_mid", 32'(bv0), 32'd0);
      drv(0, 0, 5, 5);
      drv(0, 0, 0, 0);
      chk("blink_on0", 32'(bv0), 32'd1);
      chk("blink_on1", 32'(bv1), 32'd1);
      for (int i = 0; i < 4; i++) drv(1283, 2, 262, 303);
      chk("blink_lit0", 32'(on0), 32'd1);
      chk("blink_lit1", 32'(on1), 32'd1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
